// File: rtl/lsu_pkg.sv
// Shared types and helpers for the load/store unit: FSM states, RV64 funct3 encodings
// and the access-size decode used by both the aligner and the top.
package lsu_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RD_REQ  = 3'd1,
    RD_WAIT = 3'd2,
    WR_REQ  = 3'd3,
    DONE    = 3'd4
  } lsu_state_e;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_D  = 3'b011;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;
  localparam logic [2:0] F3_WU = 3'b110;

  // Access size in bytes from funct3[1:0] (00=1, 01=2, 10=4, 11=8).
  function automatic logic [3:0] access_size(input logic [1:0] sz);
    logic [3:0] bytes;
    case (sz)
      2'b00:   bytes = 4'd1;
      2'b01:   bytes = 4'd2;
      2'b10:   bytes = 4'd4;
      default: bytes = 4'd8;
    endcase
    return bytes;
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational data aligner: extracts/extends sub-word loads from a 64-bit word and
// merges sub-word store data into the low bytes of a previously read word.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [2:0]  funct3_i,
  input  logic [63:0] load_word_i,
  input  logic [63:0] store_word_i,
  input  logic [63:0] wdata_i,
  output logic [63:0] load_data_o,
  output logic [63:0] store_data_o
);

  logic [3:0] size_s;

  assign size_s = access_size(funct3_i[1:0]);

  // Load extract with sign or zero extension; the unused encoding 111 reads as zero.
  always_comb begin
    load_data_o = 64'd0;
    case (funct3_i)
      F3_B:    load_data_o = {{56{load_word_i[7]}}, load_word_i[7:0]};
      F3_H:    load_data_o = {{48{load_word_i[15]}}, load_word_i[15:0]};
      F3_W:    load_data_o = {{32{load_word_i[31]}}, load_word_i[31:0]};
      F3_D:    load_data_o = load_word_i;
      F3_BU:   load_data_o = {56'd0, load_word_i[7:0]};
      F3_HU:   load_data_o = {48'd0, load_word_i[15:0]};
      F3_WU:   load_data_o = {32'd0, load_word_i[31:0]};
      default: load_data_o = 64'd0;
    endcase
  end

  // Store merge: low access_size bytes come from wdata, the rest from the read word.
  always_comb begin
    store_data_o = 64'd0;
    for (int i = 0; i < 8; i++) begin
      if (4'(i) < size_s) begin
        store_data_o[8*i +: 8] = wdata_i[8*i +: 8];
      end else begin
        store_data_o[8*i +: 8] = store_word_i[8*i +: 8];
      end
    end
  end

endmodule

// File: rtl/load_store_unit.sv
// Memory-access stage: one load/store per handshake against a whole-word data memory,
// with read-modify-write for sub-word stores. Optional MISALIGN_TRAP_EN adds o_misaligned.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_req,
  input  logic              i_is_store,
  input  logic [2:0]        i_funct3,
  input  logic [ADDR_W-1:0] i_base,
  input  logic [ADDR_W-1:0] i_imm,
  input  logic [DATA_W-1:0] i_wdata,
  output logic              o_ready,
  output logic              o_done,
  output logic [DATA_W-1:0] o_rdata,
  output logic [ADDR_W-1:0] o_mem_r_addr,
  output logic [ADDR_W-1:0] o_mem_w_addr,
  output logic [DATA_W-1:0] o_mem_wdata,
  output logic              o_MemRead,
  output logic              o_MemWrite,
  input  logic              i_mem_valid,
  input  logic [DATA_W-1:0] i_mem_data
`ifdef MISALIGN_TRAP_EN
  ,
  output logic              o_misaligned
`endif
);

  lsu_state_e        state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_sum_s;
  logic [2:0]        funct3_q;
  logic              is_store_q;
  logic [DATA_W-1:0] wdata_q, word_q, rdata_q;
  logic [DATA_W-1:0] load_data_s, store_data_s;
  logic              accept_s, mem_hit_s, misaligned_s;

  assign accept_s   = i_req & (state_q == IDLE);
  assign addr_sum_s = i_base + i_imm;
  assign mem_hit_s  = (state_q == RD_WAIT) & i_mem_valid;

`ifdef MISALIGN_TRAP_EN
  logic mis_q;

  // Alignment check on the freshly summed address, against the access size.
  always_comb begin
    misaligned_s = 1'b0;
    case (i_funct3[1:0])
      2'b00:   misaligned_s = 1'b0;
      2'b01:   misaligned_s = addr_sum_s[0];
      2'b10:   misaligned_s = |addr_sum_s[1:0];
      default: misaligned_s = |addr_sum_s[2:0];
    endcase
  end
`else
  assign misaligned_s = 1'b0;
`endif

  lsu_align u_align (
    .funct3_i     (funct3_q),
    .load_word_i  (i_mem_data),
    .store_word_i (word_q),
    .wdata_i      (wdata_q),
    .load_data_o  (load_data_s),
    .store_data_o (store_data_s)
  );

  // FSM state register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state; full-word stores skip the read, trapped ops skip memory entirely.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (!accept_s) begin
          state_d = IDLE;
        end else if (misaligned_s) begin
          state_d = DONE;
        end else if (i_is_store && (i_funct3[1:0] == 2'b11)) begin
          state_d = WR_REQ;
        end else begin
          state_d = RD_REQ;
        end
      end
      RD_REQ:  state_d = RD_WAIT;
      RD_WAIT: begin
        if (i_mem_valid) begin
          state_d = is_store_q ? WR_REQ : DONE;
        end else begin
          state_d = RD_WAIT;
        end
      end
      WR_REQ:  state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Request capture on accept and read-data capture on the memory response.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      addr_q     <= {ADDR_W{1'b0}};
      funct3_q   <= 3'd0;
      is_store_q <= 1'b0;
      wdata_q    <= {DATA_W{1'b0}};
      word_q     <= {DATA_W{1'b0}};
      rdata_q    <= {DATA_W{1'b0}};
`ifdef MISALIGN_TRAP_EN
      mis_q      <= 1'b0;
`endif
    end else begin
      if (accept_s) begin
        addr_q     <= addr_sum_s;
        funct3_q   <= i_funct3;
        is_store_q <= i_is_store;
        wdata_q    <= i_wdata;
`ifdef MISALIGN_TRAP_EN
        mis_q      <= misaligned_s;
`endif
      end
      if (mem_hit_s) begin
        word_q <= i_mem_data;
        if (!is_store_q) begin
          rdata_q <= load_data_s;
        end
      end
    end
  end

  // FSM outputs; address/data buses are held at zero whenever their strobe is low.
  always_comb begin
    o_ready      = 1'b0;
    o_done       = 1'b0;
    o_MemRead    = 1'b0;
    o_MemWrite   = 1'b0;
    o_mem_r_addr = {ADDR_W{1'b0}};
    o_mem_w_addr = {ADDR_W{1'b0}};
    o_mem_wdata  = {DATA_W{1'b0}};
    case (state_q)
      IDLE:   o_ready = 1'b1;
      RD_REQ: begin
        o_MemRead    = 1'b1;
        o_mem_r_addr = addr_q;
      end
      WR_REQ: begin
        o_MemWrite   = 1'b1;
        o_mem_w_addr = addr_q;
        o_mem_wdata  = store_data_s;
      end
      DONE:    o_done = 1'b1;
      default: o_ready = 1'b0;
    endcase
  end

  assign o_rdata = rdata_q;

`ifdef MISALIGN_TRAP_EN
  assign o_misaligned = (state_q == DONE) & mis_q;
`endif

endmodule

// File: tb/tb_load_store_unit.sv
// Directed self-checking bench for load_store_unit with a byte-addressed memory model
// that returns read data two cycles after the read strobe.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req, is_store;
  logic [2:0]  funct3;
  logic [63:0] base, imm, wdata;
  logic        ready, done, mr, mw;
  logic [63:0] rdata, raddr, waddr, mwdata;
  logic        mvalid;
  logic [63:0] mdata;
`ifdef MISALIGN_TRAP_EN
  logic        misaligned;
`endif

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  load_store_unit dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_req        (req),
    .i_is_store   (is_store),
    .i_funct3     (funct3),
    .i_base       (base),
    .i_imm        (imm),
    .i_wdata      (wdata),
    .o_ready      (ready),
    .o_done       (done),
    .o_rdata      (rdata),
    .o_mem_r_addr (raddr),
    .o_mem_w_addr (waddr),
    .o_mem_wdata  (mwdata),
    .o_MemRead    (mr),
    .o_MemWrite   (mw),
    .i_mem_valid  (mvalid),
    .i_mem_data   (mdata)
`ifdef MISALIGN_TRAP_EN
    ,
    .o_misaligned (misaligned)
`endif
  );

  // Byte-addressed memory model, 256 bytes, read data valid two cycles after MemRead.
  logic [7:0]  mem [0:255];
  logic        p1;
  logic [63:0] a1;

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    p1 = 1'b0; a1 = 64'd0; mvalid = 1'b0; mdata = 64'd0;
  end

  always @(posedge clk) begin
    if (mw) begin
      for (int b = 0; b < 8; b++) mem[8'(waddr + 64'(b))] <= mwdata[8*b +: 8];
    end
    p1     <= mr;
    a1     <= raddr;
    mvalid <= p1;
    if (p1) begin
      for (int b = 0; b < 8; b++) mdata[8*b +: 8] <= mem[8'(a1 + 64'(b))];
    end
  end

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  int          done_k, rd_k, rd_n, wr_n, both_n, mis_n;
  logic [63:0] raddr_s, waddr_s, wdata_s;

  task automatic run_op(input logic st, input logic [2:0] f3, input logic [63:0] b,
                        input logic [63:0] im, input logic [63:0] wd);
    @(negedge clk);
    is_store = st; funct3 = f3; base = b; imm = im; wdata = wd; req = 1'b1;
    done_k = 0; rd_k = 0; rd_n = 0; wr_n = 0; both_n = 0; mis_n = 0;
    raddr_s = 64'd0; waddr_s = 64'd0; wdata_s = 64'd0;
    for (int k = 1; k <= 20 && done_k == 0; k++) begin
      @(negedge clk);
      if (k == 1) req = 1'b0;
      if (mr) begin rd_n++; rd_k = k; raddr_s = raddr; end
      if (mw) begin wr_n++; waddr_s = waddr; wdata_s = mwdata; end
      if (mr && mw) both_n++;
`ifdef MISALIGN_TRAP_EN
      if (misaligned) mis_n++;
`endif
      if (done) done_k = k;
    end
  endtask

  task automatic load(input logic [2:0] f3, input logic [63:0] addr);
    run_op(1'b0, f3, addr, 64'd0, 64'd0);
  endtask

  int first_rd, second_rd, done_cnt, wr_cnt;

  initial begin
    rst_n = 1'b0; req = 1'b0; is_store = 1'b0; funct3 = 3'd0;
    base = 64'd0; imm = 64'd0; wdata = 64'd0;
    repeat (3) @(negedge clk);
    check("rst_ready", 64'(ready), 64'd1);
    check("rst_done", 64'(done), 64'd0);
    check("rst_rdata", rdata, 64'd0);
    check("rst_strobes", 64'({mr, mw}), 64'd0);
    rst_n = 1'b1;

    // SD base 0x10 + 8
    run_op(1'b1, 3'b011, 64'h10, 64'h8, 64'h1122334455667788);
    check("sd_done_cycle", 64'(done_k), 64'd2);
    check("sd_reads", 64'(rd_n), 64'd0);
    check("sd_writes", 64'(wr_n), 64'd1);
    check("sd_waddr", waddr_s, 64'h18);
    check("sd_wdata", wdata_s, 64'h1122334455667788);

    load(3'b011, 64'h18);
    check("ld_rd_cycle", 64'(rd_k), 64'd1);
    check("ld_raddr", raddr_s, 64'h18);
    check("ld_done_cycle", 64'(done_k), 64'd4);
    check("ld_rdata", rdata, 64'h1122334455667788);

    // SB with junk above the low byte
    run_op(1'b1, 3'b000, 64'h18, 64'h0, 64'hA5A5A5A512345680);
    check("sb_done_cycle", 64'(done_k), 64'd5);
    check("sb_rw_counts", 64'({rd_n[3:0], wr_n[3:0]}), 64'h11);
    check("sb_wdata", wdata_s, 64'h1122334455667780);
    check("sb_rdata_kept", rdata, 64'h1122334455667788);

    load(3'b000, 64'h18);
    check("lb", rdata, 64'hFFFFFFFFFFFFFF80);
    load(3'b100, 64'h18);
    check("lbu", rdata, 64'h80);
    load(3'b011, 64'h18);
    check("ld_after_sb", rdata, 64'h1122334455667780);

    // SW at 0x20-4 = 0x1C overlapping the upper half of the word at 0x18
    run_op(1'b1, 3'b010, 64'h20, 64'hFFFFFFFFFFFFFFFC, 64'hCAFEBABEDEADBEEF);
    check("sw_done_cycle", 64'(done_k), 64'd5);
    check("sw_waddr", waddr_s, 64'h1C);
    check("sw_wdata", wdata_s, 64'h00000000DEADBEEF);
    check("sw_both_strobes", 64'(both_n), 64'd0);
    check("sw_rdata_kept", rdata, 64'h1122334455667780);

    load(3'b110, 64'h1C);
    check("lwu", rdata, 64'h00000000DEADBEEF);
    load(3'b010, 64'h1C);
    check("lw", rdata, 64'hFFFFFFFFDEADBEEF);
    load(3'b001, 64'h1C);
    check("lh", rdata, 64'hFFFFFFFFFFFFBEEF);
    load(3'b101, 64'h1C);
    check("lhu", rdata, 64'h000000000000BEEF);
    load(3'b011, 64'h18);
    check("ld_after_sw", rdata, 64'hDEADBEEF55667780);
    load(3'b111, 64'h18);
    check("f3_111", rdata, 64'd0);

    // LH at odd address 0x19
    load(3'b000, 64'h18);
    load(3'b001, 64'h19);
`ifdef MISALIGN_TRAP_EN
    check("mis_done_cycle", 64'(done_k), 64'd1);
    check("mis_flag", 64'(mis_n), 64'd1);
    check("mis_no_mem", 64'(rd_n + wr_n), 64'd0);
    check("mis_rdata_kept", rdata, 64'hFFFFFFFFFFFFFF80);
`else
    check("lh_odd_done", 64'(done_k), 64'd4);
    check("lh_odd", rdata, 64'h0000000000006677);
`endif

    // i_req held high through a busy load: second accept only after o_done
    @(negedge clk);
    is_store = 1'b0; funct3 = 3'b011; base = 64'h18; imm = 64'd0; req = 1'b1;
    first_rd = 0; second_rd = 0; done_cnt = 0;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      if (k == 6) req = 1'b0;
      if (mr) begin
        if (first_rd == 0) first_rd = k;
        else if (second_rd == 0) second_rd = k;
      end
      if (done) done_cnt++;
    end
    check("busy_first_rd", 64'(first_rd), 64'd1);
    check("busy_second_rd", 64'(second_rd), 64'd6);
    check("busy_done_cnt", 64'(done_cnt), 64'd2);

    // Reset during the read phase of an SW abandons the write
    @(negedge clk);
    is_store = 1'b1; funct3 = 3'b010; base = 64'h40; imm = 64'd0;
    wdata = 64'h55555555; req = 1'b1;
    @(negedge clk);
    req = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midrst_ready", 64'(ready), 64'd1);
    wr_cnt = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (mw) wr_cnt++;
    end
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (mw) wr_cnt++;
    end
    check("midrst_no_write", 64'(wr_cnt), 64'd0);
    check("midrst_rdata", rdata, 64'd0);
    load(3'b011, 64'h40);
    check("midrst_mem", rdata, 64'd0);
    check("midrst_ld_done", 64'(done_k), 64'd4);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
